lsu: RTL and testbench

Load/store stage that sits directly downstream of the execute stage and upstream of write-back. Accepts one instruction at a time over the valid/ready stage handshake. Memory ops go out as a single AXI4-Lite transaction; the unit aligns, masks and sign-extends load data. Non-memory ops pass the ALU result through unchanged, with one cycle of latency.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 37 +++
 rtl/lsu.sv | 207 ++++++++++++++++++++
 tb/tb_lsu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;

    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

    localparam logic [3:0]  STRB_B = 4'h1;
    localparam logic [3:0]  STRB_H = 4'h3;
    localparam logic [3:0]  STRB_W = 4'hF;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic       is_half,
                                           input logic       is_word);
        return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: load extraction/sign-extension and store
// data/strobe placement within the 32-bit bus word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rmask,
    input  logic        m_signed,
    output logic [31:0] load_data,
    input  logic [31:0] rsb,
    input  logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [4:0]  shamt_s;
    logic [31:0] masked_s;

    assign shamt_s  = {addr_lo, 3'b000};
    assign masked_s = (rdata >> shamt_s) & rmask;
    assign wdata    = rsb << shamt_s;
    assign wstrb    = wmask << addr_lo;

    // Replicate the top bit of a byte/half load into the upper bits when signed.
    always_comb begin
        load_data = masked_s;
        if (m_signed && (rmask == MASK_B) && masked_s[7]) begin
            load_data = masked_s | 32'hFFFF_FF00;
        end else if (m_signed && (rmask == MASK_H) && masked_s[15]) begin
            load_data = masked_s | 32'hFFFF_0000;
        end else begin
            load_data = masked_s;
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one instruction at a time, one AXI4-Lite transaction per
// memory op, pass-through for everything else.
module lsu
    import lsu_pkg::*;
#(
    parameter int WB_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_receive_valid,
    output logic            lsu_send_ready,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     rsb_i,
    input  logic            ren_i,
    input  logic            wen_i,
    input  logic [7:0]      wmask_i,
    input  logic [31:0]     rmask_i,
    input  logic            m_signed_i,
    input  logic [WB_W-1:0] wb_info_i,
    output logic            lsu_send_valid,
    input  logic            lsu_receive_ready,
    output logic [31:0]     result_o,
    output logic            fault_o,
    output logic [WB_W-1:0] wb_info_o,
    output logic [31:0]     araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [31:0]     awaddr,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    lsu_state_e  state_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] rmask_r;
    logic        signed_r;
    logic        aw_done_r;
    logic        w_done_r;

    logic [1:0]  addr_lo_s;
    logic [31:0] load_data_s;
    logic [31:0] wdata_s;
    logic [3:0]  wstrb_s;
    logic        misalign_s;
    logic        aw_ok_s;
    logic        w_ok_s;
    logic        unused_s;

    assign unused_s       = ^wmask_i[7:4];
    assign lsu_send_ready = (state_r == ST_IDLE);
    // Store alignment only matters at accept time; loads align against the held address.
    assign addr_lo_s      = (state_r == ST_IDLE) ? addr_i[1:0] : addr_lo_r;
    assign aw_ok_s        = aw_done_r || (awvalid && awready);
    assign w_ok_s         = w_done_r || (wvalid && wready);

    lsu_align u_align (
        .addr_lo   (addr_lo_s),
        .rdata     (rdata),
        .rmask     (rmask_r),
        .m_signed  (signed_r),
        .load_data (load_data_s),
        .rsb       (rsb_i),
        .wmask     (wmask_i[3:0]),
        .wdata     (wdata_s),
        .wstrb     (wstrb_s)
    );

    // Access size comes from wmask for stores (store wins) and rmask for loads.
    always_comb begin
        misalign_s = 1'b0;
        if (wen_i) begin
            misalign_s = is_misaligned(addr_i[1:0], wmask_i[3:0] == STRB_H,
                                       wmask_i[3:0] == STRB_W);
        end else if (ren_i) begin
            misalign_s = is_misaligned(addr_i[1:0], rmask_i == MASK_H,
                                       rmask_i == MASK_W);
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Main FSM: holding registers, AXI channel valids/readies and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            addr_lo_r      <= 2'b00;
            rmask_r        <= 32'h0;
            signed_r       <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            lsu_send_valid <= 1'b0;
            result_o       <= 32'h0;
            fault_o        <= 1'b0;
            wb_info_o      <= '0;
            araddr         <= 32'h0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            awaddr         <= 32'h0;
            awvalid        <= 1'b0;
            wdata          <= 32'h0;
            wstrb          <= 4'h0;
            wvalid         <= 1'b0;
            bready         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lsu_receive_valid) begin
                        addr_lo_r <= addr_i[1:0];
                        rmask_r   <= rmask_i;
                        signed_r  <= m_signed_i;
                        wb_info_o <= wb_info_i;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        if ((ren_i || wen_i) && misalign_s) begin
                            result_o       <= 32'h0;
                            fault_o        <= 1'b1;
                            lsu_send_valid <= 1'b1;
                            state_r        <= ST_DONE;
                        end else if (wen_i) begin
                            awaddr  <= {addr_i[31:2], 2'b00};
                            wdata   <= wdata_s;
                            wstrb   <= wstrb_s;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_r <= ST_WREQ;
                        end else if (ren_i) begin
                            araddr  <= {addr_i[31:2], 2'b00};
                            arvalid <= 1'b1;
                            state_r <= ST_RADDR;
                        end else begin
                            result_o       <= addr_i;
                            fault_o        <= 1'b0;
                            lsu_send_valid <= 1'b1;
                            state_r        <= ST_DONE;
                        end
                    end
                end
                ST_RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (rvalid) begin
                        rready         <= 1'b0;
                        result_o       <= load_data_s;
                        fault_o        <= (rresp != RESP_OKAY);
                        lsu_send_valid <= 1'b1;
                        state_r        <= ST_DONE;
                    end
                end
                ST_WREQ: begin
                    if (awvalid && awready) begin
                        awvalid   <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid   <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_ok_s && w_ok_s) begin
                        bready  <= 1'b1;
                        state_r <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        bready         <= 1'b0;
                        result_o       <= 32'h0;
                        fault_o        <= (bresp != RESP_OKAY);
                        lsu_send_valid <= 1'b1;
                        state_r        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (lsu_receive_ready) begin
                        lsu_send_valid <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    arvalid        <= 1'b0;
                    rready         <= 1'b0;
                    awvalid        <= 1'b0;
                    wvalid         <= 1'b0;
                    bready         <= 1'b0;
                    lsu_send_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; the bench plays the AXI4-Lite slave
// and the write-back stage cycle by cycle.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_receive_valid;
    logic        lsu_send_ready;
    logic [31:0] addr_i, rsb_i, rmask_i;
    logic        ren_i, wen_i, m_signed_i;
    logic [7:0]  wmask_i;
    logic [63:0] wb_info_i, wb_info_o;
    logic        lsu_send_valid, lsu_receive_ready;
    logic [31:0] result_o;
    logic        fault_o;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    lsu #(.WB_W(64)) dut (
        .clk(clk), .rst(rst),
        .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
        .addr_i(addr_i), .rsb_i(rsb_i), .ren_i(ren_i), .wen_i(wen_i),
        .wmask_i(wmask_i), .rmask_i(rmask_i), .m_signed_i(m_signed_i),
        .wb_info_i(wb_info_i), .lsu_send_valid(lsu_send_valid),
        .lsu_receive_ready(lsu_receive_ready), .result_o(result_o),
        .fault_o(fault_o), .wb_info_o(wb_info_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, input logic [7:0] wm, input logic [31:0] rm,
                          input logic sg, input logic [63:0] wb);
        addr_i = a; rsb_i = d; ren_i = rd; wen_i = wr; wmask_i = wm;
        rmask_i = rm; m_signed_i = sg; wb_info_i = wb;
        lsu_receive_valid = 1'b1;
        cyc();
        lsu_receive_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] rm,
                           input logic sg, input logic [31:0] rd_v, input logic [1:0] rr,
                           input logic [31:0] exp_araddr, input logic [31:0] exp_res,
                           input logic exp_fault);
        accept(a, 32'h0, 1'b1, 1'b0, 8'h00, rm, sg, 64'h1111_2222_3333_4444);
        check({tag, "_arvalid"}, arvalid, 1'b1);
        check({tag, "_araddr"}, araddr, exp_araddr);
        check({tag, "_early_sv"}, lsu_send_valid, 1'b0);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        check({tag, "_arvalid_drop"}, arvalid, 1'b0);
        check({tag, "_rready"}, rready, 1'b1);
        rvalid = 1'b1; rdata = rd_v; rresp = rr;
        cyc();
        rvalid = 1'b0; rresp = 2'b00;
        check({tag, "_send_valid"}, lsu_send_valid, 1'b1);
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_fault"}, fault_o, exp_fault);
        check({tag, "_wb_info"}, wb_info_o, 64'h1111_2222_3333_4444);
        cyc();
        check({tag, "_back_ready"}, lsu_send_ready, 1'b1);
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] wm, input int aw_delay, input logic [1:0] br,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                            input int exp_aw_cyc, input logic exp_fault);
        int aw_cyc = 0;
        int w_cyc = 0;
        accept(a, d, 1'b0, 1'b1, wm, 32'h0, 1'b0, 64'h5555_6666_7777_8888);
        check({tag, "_awaddr"}, awaddr, {a[31:2], 2'b00});
        check({tag, "_wdata"}, wdata, exp_wdata);
        check({tag, "_wstrb"}, wstrb, exp_wstrb);
        check({tag, "_no_arvalid"}, arvalid, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (!awvalid && !wvalid) break;
            if (awvalid) aw_cyc++;
            if (wvalid) w_cyc++;
            awready = (k == aw_delay);
            wready  = (k == 0);
            cyc();
            awready = 1'b0;
            wready  = 1'b0;
        end
        check({tag, "_aw_cycles"}, aw_cyc, exp_aw_cyc);
        check({tag, "_w_cycles"}, w_cyc, 1);
        check({tag, "_bready"}, bready, 1'b1);
        bvalid = 1'b1; bresp = br;
        cyc();
        bvalid = 1'b0; bresp = 2'b00;
        check({tag, "_bready_drop"}, bready, 1'b0);
        check({tag, "_send_valid"}, lsu_send_valid, 1'b1);
        check({tag, "_result"}, result_o, 32'h0);
        check({tag, "_fault"}, fault_o, exp_fault);
        cyc();
        check({tag, "_back_ready"}, lsu_send_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        lsu_receive_valid = 1'b0; lsu_receive_ready = 1'b1;
        addr_i = 32'h0; rsb_i = 32'h0; ren_i = 1'b0; wen_i = 1'b0; wmask_i = 8'h0;
        rmask_i = 32'h0; m_signed_i = 1'b0; wb_info_i = 64'h0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

        #12;
        check("rst_send_ready", lsu_send_ready, 1'b1);
        check("rst_send_valid", lsu_send_valid, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_wb_info", wb_info_o, 64'h0);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, fault_o}, 6'b0);
        rst = 1'b1;

        // Non-memory pass-through, one cycle latency, no bus activity
        accept(32'h0000_1234, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 64'hA5A5_0000_1111_2222);
        check("nm_send_valid", lsu_send_valid, 1'b1);
        check("nm_result", result_o, 32'h0000_1234);
        check("nm_wb_info", wb_info_o, 64'hA5A5_0000_1111_2222);
        check("nm_no_axi", {arvalid, awvalid, wvalid}, 3'b000);
        check("nm_send_ready", lsu_send_ready, 1'b0);
        cyc();
        check("nm_back_ready", lsu_send_ready, 1'b1);
        check("nm_sv_drop", lsu_send_valid, 1'b0);

        do_load("ld_sb", 32'h8000_0003, 32'h0000_00FF, 1'b1, 32'h8012_3456, 2'b00,
                32'h8000_0000, 32'hFFFF_FF80, 1'b0);
        do_load("ld_hu", 32'h8000_0002, 32'h0000_FFFF, 1'b0, 32'hBEEF_1234, 2'b00,
                32'h8000_0000, 32'h0000_BEEF, 1'b0);
        do_load("ld_hs", 32'h8000_0006, 32'h0000_FFFF, 1'b1, 32'h8001_0000, 2'b00,
                32'h8000_0004, 32'hFFFF_8001, 1'b0);
        do_load("ld_w_err", 32'h8000_0008, 32'hFFFF_FFFF, 1'b0, 32'hCAFE_F00D, 2'b10,
                32'h8000_0008, 32'hCAFE_F00D, 1'b1);

        do_store("st_h", 32'h8000_0002, 32'h0000_BEEF, 8'h03, 0, 2'b00,
                 32'hBEEF_0000, 4'hC, 1, 1'b0);
        do_store("st_h_awdly", 32'h8000_0002, 32'h0000_BEEF, 8'h03, 3, 2'b00,
                 32'hBEEF_0000, 4'hC, 4, 1'b0);
        do_store("st_b_berr", 32'h8000_0011, 32'h0000_00AB, 8'h01, 0, 2'b10,
                 32'h0000_AB00, 4'h2, 1, 1'b1);

        // Misaligned word load faults without touching the bus
        accept(32'h8000_0002, 32'h0, 1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 1'b0, 64'h0);
        check("mis_no_arvalid", arvalid, 1'b0);
        check("mis_send_valid", lsu_send_valid, 1'b1);
        check("mis_fault", fault_o, 1'b1);
        check("mis_result", result_o, 32'h0);
        cyc();
        check("mis_back_ready", lsu_send_ready, 1'b1);

        // Backpressure in DONE: outputs hold, a new valid is ignored
        lsu_receive_ready = 1'b0;
        accept(32'h0000_5678, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        for (int i = 0; i < 5; i++) begin
            check("bp_send_valid", lsu_send_valid, 1'b1);
            check("bp_result", result_o, 32'h0000_5678);
            check("bp_wb_info", wb_info_o, 64'hDEAD_BEEF_0123_4567);
            check("bp_send_ready", lsu_send_ready, 1'b0);
            if (i == 1) begin
                addr_i = 32'h0000_9999; wb_info_i = 64'h0; lsu_receive_valid = 1'b1;
            end
            cyc();
        end
        lsu_receive_valid = 1'b0;
        lsu_receive_ready = 1'b1;
        cyc();
        check("bp_release_ready", lsu_send_ready, 1'b1);
        cyc();
        check("bp_no_accept", lsu_send_valid, 1'b0);
        check("bp_result_kept", result_o, 32'h0000_5678);

        // Reset while waiting for read data
        accept(32'h8000_0000, 32'h0, 1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 1'b0, 64'h0);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        check("rl_rready", rready, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rl_valids_drop", {arvalid, rready, lsu_send_valid}, 3'b000);
        #2 rst = 1'b1;
        cyc();
        check("rl_send_ready", lsu_send_ready, 1'b1);
        check("rl_rready_idle", rready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
